// File: rtl/dbg_pkg.sv
// Shared definitions for the debug-monitor sequencer: command encodings, FSM states, address width.
package dbg_pkg;

    localparam int DBG_ADR_W = 12;

    typedef enum logic [1:0] {
        DBG_OP_RD   = 2'd0,
        DBG_OP_WR   = 2'd1,
        DBG_OP_RUN  = 2'd2,
        DBG_OP_STOP = 2'd3
    } dbg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HALT   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_ACC    = 3'd3,
        ST_RDWAIT = 3'd4,
        ST_RESUME = 3'd5,
        ST_RESP   = 3'd6
    } dbg_state_e;

endpackage

// File: rtl/dbg_drain_timer.sv
// Pipeline drain timer: 4-bit down-counter loaded during HALT, o_done flags the last DRAIN cycle.
module dbg_drain_timer #(
    parameter int DRAIN_CYC = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam logic [3:0] LOAD_VAL = 4'(DRAIN_CYC);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    assign o_done = i_en && (r_cnt == 4'd1);

endmodule

// File: rtl/dbg_mem_sequencer.sv
// Debug-monitor sequencer: host RD/WR/RUN/STOP commands to cpu_top run control and RAM monitor ports.
// Build option DBG_AUTO_HALT_EN: RD/WR while running halt, drain, access, then resume the CPU.
//
// state  | meaning
// IDLE   | ready for a command
// HALT   | quit_cmd pulse, drain timer loads
// DRAIN  | wait DRAIN_CYC cycles, capture PC on the last one
// ACC    | RAM access (write strobe or first read cycle)
// RDWAIT | remaining read-latency cycles
// RESUME | cpu_start pulse
// RESP   | response held until rsp_ready
module dbg_mem_sequencer
    import dbg_pkg::*;
#(
    parameter int DRAIN_CYC = 5,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic                 cmd_isp,
    input  logic [DBG_ADR_W-1:0] cmd_adr,
    input  logic [31:0]          cmd_wdata,
    input  logic [29:0]          cmd_start_adr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 cpu_running,
    output logic                 cpu_start,
    output logic                 quit_cmd,
    output logic [29:0]          start_adr,
    input  logic [31:0]          pc_data,
    output logic [DBG_ADR_W-1:0] i_ram_radr,
    output logic [DBG_ADR_W-1:0] i_ram_wadr,
    output logic [31:0]          i_ram_wdata,
    output logic                 i_ram_wen,
    output logic                 i_read_sel,
    input  logic [31:0]          i_ram_rdata,
    output logic [DBG_ADR_W-1:0] d_ram_radr,
    output logic [DBG_ADR_W-1:0] d_ram_wadr,
    output logic [31:0]          d_ram_wdata,
    output logic                 d_ram_wen,
    output logic                 d_read_sel,
    input  logic [31:0]          d_ram_rdata
);

`ifdef DBG_AUTO_HALT_EN
    localparam bit AUTO_HALT_EN = 1'b1;
`else
    localparam bit AUTO_HALT_EN = 1'b0;
`endif

    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    dbg_state_e             r_state;
    dbg_state_e             w_next;
    dbg_state_e             w_after;
    dbg_op_e                r_op;
    logic                   r_isp;
    logic [DBG_ADR_W-1:0]   r_adr;
    logic [31:0]            r_wdata;
    logic [29:0]            r_start_adr;
    logic [29:0]            r_resume_pc;
    logic                   r_running;
    logic                   r_auto;
    logic [31:0]            r_rsp_data;
    logic                   r_rsp_err;
    logic [1:0]             r_lat_cnt;

    dbg_op_e                w_op;
    logic                   w_mem_op;
    logic                   w_reject;
    logic                   w_accept;
    logic                   w_rd_act;
    logic                   w_drain_done;

    assign w_op     = dbg_op_e'(cmd_op);
    assign w_mem_op = (w_op == DBG_OP_RD) || (w_op == DBG_OP_WR);
    assign w_reject = r_running && ((w_mem_op && !AUTO_HALT_EN) || (w_op == DBG_OP_RUN));
    assign w_accept = (r_state == ST_IDLE) && cmd_valid;
    assign w_rd_act = ((r_state == ST_ACC) || (r_state == ST_RDWAIT)) && (r_op == DBG_OP_RD);
    assign w_after  = r_auto ? ST_RESUME : ST_RESP;
    assign cpu_running = r_running;

    dbg_drain_timer #(
        .DRAIN_CYC(DRAIN_CYC)
    ) u_drain_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (r_state == ST_HALT),
        .i_en   (r_state == ST_DRAIN),
        .o_done (w_drain_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= DBG_OP_RD;
            r_isp       <= 1'b0;
            r_adr       <= '0;
            r_wdata     <= '0;
            r_start_adr <= '0;
            r_resume_pc <= '0;
            r_running   <= 1'b0;
            r_auto      <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_lat_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_op        <= w_op;
                r_isp       <= cmd_isp;
                r_adr       <= cmd_adr;
                r_wdata     <= cmd_wdata;
                r_start_adr <= cmd_start_adr;
                r_auto      <= w_mem_op && r_running && AUTO_HALT_EN;
                r_rsp_err   <= w_reject;
                r_rsp_data  <= ((w_op == DBG_OP_STOP) && !r_running) ? pc_data : 32'd0;
            end
            if ((r_state == ST_DRAIN) && w_drain_done) begin
                r_resume_pc <= pc_data[31:2];
                if (r_op == DBG_OP_STOP) begin
                    r_running  <= 1'b0;
                    r_rsp_data <= {pc_data[31:2], 2'b00};
                end
            end
            if ((r_state == ST_RESUME) && (r_op == DBG_OP_RUN)) begin
                r_running <= 1'b1;
            end
            // The last cycle of the read window is when the RAM data is valid.
            if (w_rd_act && (r_lat_cnt == 2'd0)) begin
                r_rsp_data <= r_isp ? i_ram_rdata : d_ram_rdata;
            end
            if ((r_state == ST_ACC) || (r_state == ST_RDWAIT)) begin
                if (r_lat_cnt != 2'd0) begin
                    r_lat_cnt <= r_lat_cnt - 2'd1;
                end
            end else begin
                r_lat_cnt <= LAT_INIT;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_err     = 1'b0;
        cpu_start   = 1'b0;
        quit_cmd    = 1'b0;
        start_adr   = '0;
        i_ram_radr  = '0;
        i_ram_wadr  = '0;
        i_ram_wdata = '0;
        i_ram_wen   = 1'b0;
        i_read_sel  = 1'b0;
        d_ram_radr  = '0;
        d_ram_wadr  = '0;
        d_ram_wdata = '0;
        d_ram_wen   = 1'b0;
        d_read_sel  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid) begin
                    if (w_reject) begin
                        w_next = ST_RESP;
                    end else begin
                        unique case (w_op)
                            DBG_OP_RD,
                            DBG_OP_WR:   w_next = r_running ? ST_HALT : ST_ACC;
                            DBG_OP_RUN:  w_next = ST_RESUME;
                            DBG_OP_STOP: w_next = r_running ? ST_HALT : ST_RESP;
                            default:     w_next = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_HALT: begin
                quit_cmd = 1'b1;
                w_next   = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_next = (r_op == DBG_OP_STOP) ? ST_RESP : ST_ACC;
                end
            end
            ST_ACC: begin
                if (r_op == DBG_OP_WR) begin
                    if (r_isp) begin
                        i_ram_wen   = 1'b1;
                        i_ram_wadr  = r_adr;
                        i_ram_wdata = r_wdata;
                    end else begin
                        d_ram_wen   = 1'b1;
                        d_ram_wadr  = r_adr;
                        d_ram_wdata = r_wdata;
                    end
                    w_next = w_after;
                end else begin
                    w_next = (r_lat_cnt == 2'd0) ? w_after : ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (r_lat_cnt == 2'd0) begin
                    w_next = w_after;
                end
            end
            ST_RESUME: begin
                cpu_start = 1'b1;
                start_adr = (r_op == DBG_OP_RUN) ? r_start_adr : r_resume_pc;
                w_next    = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_data  = r_rsp_data;
                rsp_err   = r_rsp_err;
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase

        if (w_rd_act) begin
            if (r_isp) begin
                i_read_sel = 1'b1;
                i_ram_radr = r_adr;
            end else begin
                d_read_sel = 1'b1;
                d_ram_radr = r_adr;
            end
        end
    end

endmodule

// File: tb/tb_dbg_mem_sequencer.sv
// Directed bench for dbg_mem_sequencer (DRAIN_CYC=5, RD_LAT=2); covers both DBG_AUTO_HALT_EN builds.
`timescale 1ns/1ps
module tb_dbg_mem_sequencer;

    localparam int DRAIN = 5;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic        cmd_isp = 1'b0;
    logic [11:0] cmd_adr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [29:0] cmd_start_adr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        cpu_running;
    logic        cpu_start;
    logic        quit_cmd;
    logic [29:0] start_adr;
    logic [31:0] pc_data = '0;
    logic [11:0] i_ram_radr, i_ram_wadr, d_ram_radr, d_ram_wadr;
    logic [31:0] i_ram_wdata, d_ram_wdata, i_ram_rdata, d_ram_rdata;
    logic        i_ram_wen, i_read_sel, d_ram_wen, d_read_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int q_cnt = 0, s_cnt = 0, dwen_cnt = 0, q_wide = 0, s_wide = 0, ovl = 0;
    logic q_prev = 1'b0, s_prev = 1'b0;
    int i_rd_cyc = 0, d_rd_cyc = 0;
    int lat;
    int q0, s0, w0;

    always #5 clk = ~clk;

    dbg_mem_sequencer #(
        .DRAIN_CYC(DRAIN),
        .RD_LAT   (LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_isp(cmd_isp),
        .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata), .cmd_start_adr(cmd_start_adr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .cpu_running(cpu_running), .cpu_start(cpu_start), .quit_cmd(quit_cmd),
        .start_adr(start_adr), .pc_data(pc_data),
        .i_ram_radr(i_ram_radr), .i_ram_wadr(i_ram_wadr), .i_ram_wdata(i_ram_wdata),
        .i_ram_wen(i_ram_wen), .i_read_sel(i_read_sel), .i_ram_rdata(i_ram_rdata),
        .d_ram_radr(d_ram_radr), .d_ram_wadr(d_ram_wadr), .d_ram_wdata(d_ram_wdata),
        .d_ram_wen(d_ram_wen), .d_read_sel(d_read_sel), .d_ram_rdata(d_ram_rdata)
    );

    // RAM model: data is valid only in the last cycle of the RD_LAT-long select window.
    function automatic logic [31:0] iram(input logic [11:0] a);
        return (a == 12'h004) ? 32'h0000_0013 : 32'h0000_0000;
    endfunction
    function automatic logic [31:0] dram(input logic [11:0] a);
        return (a == 12'h020) ? 32'hCAFE_F00D : 32'h0000_0000;
    endfunction

    always @(posedge clk) begin
        i_rd_cyc <= i_read_sel ? i_rd_cyc + 1 : 0;
        d_rd_cyc <= d_read_sel ? d_rd_cyc + 1 : 0;
    end
    always_comb i_ram_rdata = (i_read_sel && i_rd_cyc == LAT - 1) ? iram(i_ram_radr) : 32'hBAD0_BAD0;
    always_comb d_ram_rdata = (d_read_sel && d_rd_cyc == LAT - 1) ? dram(d_ram_radr) : 32'hBAD0_BAD0;

    always @(negedge clk) begin
        q_prev <= quit_cmd;
        s_prev <= cpu_start;
        if (quit_cmd) q_cnt <= q_cnt + 1;
        if (cpu_start) s_cnt <= s_cnt + 1;
        if (d_ram_wen) dwen_cnt <= dwen_cnt + 1;
        if (quit_cmd && q_prev) q_wide <= q_wide + 1;
        if (cpu_start && s_prev) s_wide <= s_wide + 1;
        if (quit_cmd && cpu_start) ovl <= ovl + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic isp, input logic [11:0] adr,
                         input logic [31:0] wd, input logic [29:0] sa);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_isp = isp;
        cmd_adr = adr; cmd_wdata = wd; cmd_start_adr = sa;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
            if (n >= 40) begin
                chk("rsp_timeout", 32'(rsp_valid), 32'd1);
                break;
            end
        end
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ctl", 32'({cpu_start, quit_cmd, cpu_running, rsp_valid, rsp_err, i_ram_wen,
                            d_ram_wen, i_read_sel, d_read_sel, cmd_ready}), 32'd0);
        rst = 1'b0;
        #1 chk("rst_ready", 32'(cmd_ready), 32'd1);

        // WR d-space, CPU stopped
        issue(2'd1, 1'b0, 12'h010, 32'hDEAD_BEEF, 30'd0);
        @(negedge clk);
        chk("wr_wen",   32'(d_ram_wen), 32'd1);
        chk("wr_wadr",  32'(d_ram_wadr), 32'h010);
        chk("wr_wdata", d_ram_wdata, 32'hDEAD_BEEF);
        chk("wr_iwen",  32'(i_ram_wen), 32'd0);
        chk("wr_rv_t1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("wr_rv_t2", 32'(rsp_valid), 32'd1);
        chk("wr_wen_t2", 32'(d_ram_wen), 32'd0);
        chk("wr_err",   32'(rsp_err), 32'd0);
        chk("wr_data",  rsp_data, 32'd0);
        take_rsp();

        // RD i-space, CPU stopped, RD_LAT=2
        issue(2'd0, 1'b1, 12'h004, 32'd0, 30'd0);
        @(negedge clk);
        chk("rd_sel_t1", 32'(i_read_sel), 32'd1);
        chk("rd_radr",   32'(i_ram_radr), 32'h004);
        chk("rd_dsel",   32'(d_read_sel), 32'd0);
        @(negedge clk);
        chk("rd_sel_t2", 32'(i_read_sel), 32'd1);
        chk("rd_rv_t2",  32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("rd_rv_t3",  32'(rsp_valid), 32'd1);
        chk("rd_data",   rsp_data, 32'h0000_0013);
        chk("rd_sel_t3", 32'(i_read_sel), 32'd0);
        @(negedge clk);
        chk("rd_hold_v", 32'(rsp_valid), 32'd1);
        chk("rd_hold_d", rsp_data, 32'h0000_0013);
        take_rsp();

        // STOP while stopped returns the raw PC
        pc_data = 32'h0000_0ABC;
        issue(2'd3, 1'b0, 12'h0, 32'd0, 30'd0);
        wait_rsp(lat);
        chk("stop_idle_lat",  32'(lat), 32'd1);
        chk("stop_idle_data", rsp_data, 32'h0000_0ABC);
        chk("stop_idle_err",  32'(rsp_err), 32'd0);
        take_rsp();

        // WR i-space at top of range
        issue(2'd1, 1'b1, 12'hFFF, 32'h1234_5678, 30'd0);
        @(negedge clk);
        chk("wri_wen",  32'(i_ram_wen), 32'd1);
        chk("wri_wadr", 32'(i_ram_wadr), 32'hFFF);
        chk("wri_dwen", 32'(d_ram_wen), 32'd0);
        wait_rsp(lat);
        take_rsp();

        // RUN from 0x40
        issue(2'd2, 1'b0, 12'h0, 32'd0, 30'h10);
        @(negedge clk);
        chk("run_start", 32'(cpu_start), 32'd1);
        chk("run_sadr",  32'(start_adr), 32'h10);
        @(negedge clk);
        chk("run_rv",    32'(rsp_valid), 32'd1);
        chk("run_err",   32'(rsp_err), 32'd0);
        chk("run_state", 32'(cpu_running), 32'd1);
        chk("run_pulse", 32'(cpu_start), 32'd0);
        take_rsp();

        // RUN while running is rejected
        s0 = s_cnt;
        issue(2'd2, 1'b0, 12'h0, 32'd0, 30'h30);
        wait_rsp(lat);
        chk("rerun_err", 32'(rsp_err), 32'd1);
        chk("rerun_lat", 32'(lat), 32'd1);
        take_rsp();
        chk("rerun_nostart", 32'(s_cnt), 32'(s0));
        chk("rerun_running", 32'(cpu_running), 32'd1);

`ifdef DBG_AUTO_HALT_EN
        // RD d-space while running: halt, drain, read, resume at the captured PC
        pc_data = 32'h0000_0058;
        issue(2'd0, 1'b0, 12'h020, 32'd0, 30'd0);
        @(negedge clk);
        chk("ah_quit", 32'(quit_cmd), 32'd1);
        for (int i = 0; i < DRAIN; i++) begin
            @(negedge clk);
            chk("ah_drain", 32'({quit_cmd, d_read_sel, cpu_start}), 32'd0);
        end
        @(negedge clk);
        chk("ah_sel_a", 32'(d_read_sel), 32'd1);
        chk("ah_radr",  32'(d_ram_radr), 32'h020);
        @(negedge clk);
        chk("ah_sel_b", 32'(d_read_sel), 32'd1);
        @(negedge clk);
        chk("ah_start", 32'(cpu_start), 32'd1);
        chk("ah_sadr",  32'(start_adr), 32'h16);
        chk("ah_sel_c", 32'(d_read_sel), 32'd0);
        @(negedge clk);
        chk("ah_rv",    32'(rsp_valid), 32'd1);
        chk("ah_data",  rsp_data, 32'hCAFE_F00D);
        chk("ah_err",   32'(rsp_err), 32'd0);
        chk("ah_run",   32'(cpu_running), 32'd1);
        take_rsp();
`else
        // WR while running is rejected without touching RAM or CPU controls
        q0 = q_cnt; w0 = dwen_cnt;
        issue(2'd1, 1'b0, 12'h010, 32'h5555_AAAA, 30'd0);
        wait_rsp(lat);
        chk("wrrun_lat",  32'(lat), 32'd1);
        chk("wrrun_err",  32'(rsp_err), 32'd1);
        chk("wrrun_data", rsp_data, 32'd0);
        take_rsp();
        chk("wrrun_nowen",  32'(dwen_cnt), 32'(w0));
        chk("wrrun_noquit", 32'(q_cnt), 32'(q0));
        chk("wrrun_run",    32'(cpu_running), 32'd1);
`endif

        // STOP while running
        pc_data = 32'h0000_0100;
        q0 = q_cnt;
        issue(2'd3, 1'b0, 12'h0, 32'd0, 30'd0);
        wait_rsp(lat);
        chk("stop_lat",  32'(lat), 32'(2 + DRAIN));
        chk("stop_data", rsp_data, 32'h0000_0100);
        chk("stop_err",  32'(rsp_err), 32'd0);
        chk("stop_run",  32'(cpu_running), 32'd0);
        take_rsp();
        chk("stop_quit", 32'(q_cnt), 32'(q0 + 1));

        // Reset during DRAIN
        issue(2'd2, 1'b0, 12'h0, 32'd0, 30'h20);
        wait_rsp(lat);
        take_rsp();
        issue(2'd3, 1'b0, 12'h0, 32'd0, 30'd0);
        @(negedge clk);
        chk("rd_halt_quit", 32'(quit_cmd), 32'd1);
        repeat (2) @(negedge clk);
        s0 = s_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctl", 32'({cpu_start, quit_cmd, cpu_running, rsp_valid, rsp_err, i_ram_wen,
                                d_ram_wen, i_read_sel, d_read_sel, cmd_ready}), 32'd0);
        chk("mid_rst_sadr", 32'(start_adr), 32'd0);
        chk("mid_rst_data", rsp_data, 32'd0);
        rst = 1'b0;
        #1 chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("mid_rst_nostart", 32'(s_cnt), 32'(s0));
        chk("mid_rst_idle", 32'({rsp_valid, cpu_running}), 32'd0);

        chk("pulse_overlap", 32'(ovl), 32'd0);
        chk("quit_width",    32'(q_wide), 32'd0);
        chk("start_width",   32'(s_wide), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dbg_mem_sequencer.md
# dbg_mem_sequencer

Debug-monitor sequencer between the host command interface (UART monitor) and `cpu_top`. It accepts single-word instruction/data RAM read and write commands plus RUN and STOP commands. It drives the `cpu_start`, `quit_cmd` and `start_adr` controls and the `i_ram_*` / `d_ram_*` monitor ports. Memory commands issued while the CPU runs are handled by halting the pipeline, draining it, performing the access, and resuming at the captured PC.

## Interface
- `DRAIN_CYC`, default 5: cycles waited after `quit_cmd` before touching RAM or sampling `pc_data`; legal range 1–15.
- `RD_LAT`, default 1: RAM read latency in cycles from address/`*_read_sel` valid to `*_ram_rdata` valid; legal range 1–3.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op` in 2: 0 = RD, 1 = WR, 2 = RUN, 3 = STOP.
- `cmd_isp` in 1: 1 = instruction RAM, 0 = data RAM.
- `cmd_adr` in 12: word address [13:2].
- `cmd_wdata` in 32: write data.
- `cmd_start_adr` in 30: RUN start address [31:2].
- `rsp_valid` out 1: response valid; held until `rsp_ready`.
- `rsp_ready` in 1: response consumed.
- `rsp_data` out 32: read data, or PC for STOP; 0 otherwise.
- `rsp_err` out 1: command rejected.
- `cpu_running` out 1: sequencer's view of the CPU state.
- `cpu_start` out 1: one-cycle pulse.
- `quit_cmd` out 1: one-cycle pulse.
- `start_adr` out 30: valid in the `cpu_start` cycle.
- `pc_data` in 32: CPU PC.
- `i_ram_radr`, `i_ram_wadr` out 12: instruction RAM read/write address.
- `i_ram_wdata` out 32: instruction RAM write data.
- `i_ram_wen` out 1: instruction RAM write enable.
- `i_read_sel` out 1: instruction RAM read select.
- `i_ram_rdata` in 32: instruction RAM read data.
- `d_ram_radr`, `d_ram_wadr` out 12: data RAM read/write address.
- `d_ram_wdata` out 32: data RAM write data.
- `d_ram_wen` out 1: data RAM write enable.
- `d_read_sel` out 1: data RAM read select.
- `d_ram_rdata` in 32: data RAM read data.

## Operation
- Command register latches `op`, `isp`, `adr`, `wdata` and `start_adr` on accept.
- `cmd_ready = (state == IDLE)`.
- States and transitions:
  - IDLE: accept a command.
  - HALT: 1 cycle, `quit_cmd = 1`.
  - DRAIN: count `DRAIN_CYC`; on the final cycle latch `resume_pc <= pc_data[31:2]`.
  - ACC: perform the access.
  - RDWAIT: wait for read data.
  - RESUME: 1 cycle, `cpu_start = 1`, `start_adr = resume_pc`.
  - RESP: hold the response.
- RD/WR with `cpu_running = 0`: IDLE → ACC.
- RD/WR with `cpu_running = 1` (DBG_AUTO_HALT_EN): IDLE → HALT → DRAIN → ACC → (RDWAIT) → RESUME → RESP.
- WR, in ACC: selected `*_ram_wen = 1` for exactly 1 cycle, with `wadr`/`wdata` from the command register; `rsp_data = 0`.
- RD: `*_read_sel = 1` and `*_ram_radr` held through ACC plus `RD_LAT - 1` RDWAIT cycles. `rsp_data` is captured from the selected `*_ram_rdata` on the cycle exactly `RD_LAT` cycles after ACC entry.
- RUN, `cpu_running = 0`: IDLE → RESUME with `start_adr = cmd_start_adr`; set `cpu_running`; then RESP.
- RUN, `cpu_running = 1`: IDLE → RESP with `rsp_err = 1`.
- STOP, `cpu_running = 1`: HALT → DRAIN; clear `cpu_running`; `rsp_data = {resume_pc, 2'b00}`.
- STOP, `cpu_running = 0`: IDLE → RESP with `rsp_data = pc_data`, `rsp_err = 0`.
- RESP: `rsp_valid = 1`. When `rsp_valid & rsp_ready`, go to IDLE; `rsp_data` and `rsp_err` are held stable until then.
- The unselected RAM's `wen` and `read_sel` stay 0. All RAM outputs are 0 outside ACC/RDWAIT.

## Timing
- Reset values: all outputs 0 except `cmd_ready = 1` once `rst` deasserts; state = IDLE; `cpu_running = 0`; `resume_pc = 0`.
- `rst` asserted mid-operation: return to IDLE immediately. No further pulses; any pending response is discarded.
- WR latency, CPU stopped: accept cycle T; `wen` at T+1; `rsp_valid` at T+2.
- RD latency, CPU stopped: `rsp_valid` at T+1+`RD_LAT`.
- Auto-halt path adds 1 + `DRAIN_CYC` cycles before ACC and 1 cycle (RESUME) after the access.
- `cpu_start` and `quit_cmd` are never asserted in the same cycle. Each is exactly 1 cycle wide.
- `cmd_valid` while `cmd_ready = 0` is ignored. The requester holds `cmd_valid` until accepted.

## Configuration
- `DBG_AUTO_HALT_EN` defined: RD/WR while running use the halt/drain/access/resume path above.
- Undefined: RD/WR while running go IDLE → RESP with `rsp_err = 1`, `rsp_data = 0`, and no RAM or CPU control activity. HALT/DRAIN are used only by STOP, and RESUME only by RUN.

## Structure
- Shared package `dbg_pkg` holds:
  - `cmd_op` encodings (`DBG_OP_RD`, `DBG_OP_WR`, `DBG_OP_RUN`, `DBG_OP_STOP`);
  - the state enum;
  - `DBG_ADR_W = 12`.
- Sub-module `dbg_drain_timer`: 4-bit down-counter loaded with `DRAIN_CYC` on HALT, with output `done` on the final count.

## Test plan
- Stopped CPU, WR d-space `adr = 0x010`, `wdata = 0xDEADBEEF` → `d_ram_wen` 1 cycle at T+1 with `d_ram_wadr = 0x010`. `rsp_valid` at T+2, `rsp_err = 0`, `rsp_data = 0`.
- Stopped CPU, RD i-space `adr = 0x004`, `RD_LAT = 2`, RAM returns 0x00000013 → `i_read_sel` high for 2 cycles; `rsp_data = 0x00000013` at T+3.
- RUN `start_adr = 0x0000_0040 >> 2`; then RD d-space with `pc_data = 0x58` at end of drain → `quit_cmd` pulse, then 5 idle cycles. After the access, `cpu_start` pulses with `start_adr = 0x16`; `cpu_running` stays 1.
- RUN while running → `rsp_err = 1`, with no `cpu_start` pulse.
- STOP while running, `pc_data = 0x0000_0100` → `rsp_data = 0x100`; `cpu_running` drops to 0.
- `rst` asserted during DRAIN → all outputs 0 next edge. No `cpu_start` is issued; `cmd_ready = 1` after release.
- `DBG_AUTO_HALT_EN` undefined, WR while running → `rsp_err = 1`, `d_ram_wen` never asserted, `quit_cmd` never asserted.
